// File: rtl/vending_machine_param_if.sv
// rtl/vending_machine_param_if.sv - coin/dispense signal bundle for the vending machine
//
// Purpose: groups the coin acceptor strobes and the dispenser/hopper pulses
// that pass between the front-end and vending_machine_param.
// Ports (signals):
//   pi_money_one, pi_money_half, pi_cancel  : strobes from the coin acceptor
//   po_beverage                             : one-cycle dispense pulse
//   po_money_one, po_money_half             : change/refund coin pulses
//   po_busy                                 : high while vending or paying out
//   po_credit[CREDIT_W-1:0]                 : held credit in half-units
// Modports: master = coin acceptor side, slave = vending machine.

interface vending_machine_param_if #(
  parameter int CREDIT_W = 4
);
  logic                pi_money_one;
  logic                pi_money_half;
  logic                pi_cancel;
  logic                po_beverage;
  logic                po_money_one;
  logic                po_money_half;
  logic                po_busy;
  logic [CREDIT_W-1:0] po_credit;

  modport master (
    output pi_money_one, pi_money_half, pi_cancel,
    input  po_beverage, po_money_one, po_money_half, po_busy, po_credit
  );

  modport slave (
    input  pi_money_one, pi_money_half, pi_cancel,
    output po_beverage, po_money_one, po_money_half, po_busy, po_credit
  );
endinterface

// File: rtl/vending_machine_param.sv
// rtl/vending_machine_param.sv - parametrised beverage vending FSM with change and refund payout
//
// Purpose: accumulates half-unit and one-unit coins against PRICE (half-units),
// vends for one cycle, then pays change (or a cancel refund) as one coin pulse
// per cycle, largest coin first.
// Ports:
//   sys_clk    : clock, all logic on the rising edge
//   sys_rst_n  : synchronous active-low reset
//   bus        : vending_machine_param_if.slave (coin strobes in, pulses/credit out)
// Optional feature: define VM_TIMEOUT_EN to build an idle counter that refunds
// held credit after TIMEOUT_CYC cycles without a coin.

module vending_machine_param #(
  parameter int PRICE       = 3,
  parameter int CREDIT_W    = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic                    sys_clk,
  input logic                    sys_rst_n,
  vending_machine_param_if.slave bus
);

  // Elaboration-time parameter sanity checks.
  if (PRICE < 1 || PRICE > (2 ** CREDIT_W) - 2) begin : g_bad_price
    $error("vending_machine_param: PRICE out of range for CREDIT_W");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("vending_machine_param: TIMEOUT_CYC must be at least 1");
  end

  localparam logic [CREDIT_W-1:0] PRICE_W = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] ONE_W   = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] TWO_W   = CREDIT_W'(2);

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    VEND   = 2'd1,
    PAYOUT = 2'd2
  } state_t;

  state_t              state;
  logic [CREDIT_W-1:0] credit;
  // In VEND this holds the full change; in PAYOUT it holds what is still owed
  // after the pulse currently on the outputs.
  logic [CREDIT_W-1:0] change;
  logic                beverage;
  logic                money_one;
  logic                money_half;
  logic                busy;

  // Both strobes together is an invalid coin and is ignored.
  logic                coin_valid;
  logic [CREDIT_W-1:0] coin_value;
  logic [CREDIT_W-1:0] sum;
  logic                timeout_hit;
  logic                refund_req;

  assign coin_valid = bus.pi_money_one ^ bus.pi_money_half;
  assign coin_value = bus.pi_money_one ? TWO_W : ONE_W;
  // Cannot overflow: credit < PRICE and a coin adds at most 2.
  assign sum        = credit + coin_value;
  assign refund_req = (bus.pi_cancel && (credit != '0)) || timeout_hit;

`ifdef VM_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] TIMEOUT_W = IDLE_W'(TIMEOUT_CYC);

  logic [IDLE_W-1:0] idle_cnt;

  assign timeout_hit = (state == ACCEPT) && (credit != '0) && !coin_valid &&
                       (idle_cnt == TIMEOUT_W);

  // Counts only while credit is held in ACCEPT with no coin arriving.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      idle_cnt <= '0;
    end else if ((state != ACCEPT) || coin_valid || (credit == '0) || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state      <= ACCEPT;
      credit     <= '0;
      change     <= '0;
      beverage   <= 1'b0;
      money_one  <= 1'b0;
      money_half <= 1'b0;
      busy       <= 1'b0;
    end else begin
      beverage   <= 1'b0;
      money_one  <= 1'b0;
      money_half <= 1'b0;
      case (state)
        ACCEPT: begin
          if (coin_valid && (sum >= PRICE_W)) begin
            state    <= VEND;
            change   <= sum - PRICE_W;
            credit   <= '0;
            beverage <= 1'b1;
            busy     <= 1'b1;
          end else if (coin_valid) begin
            credit <= sum;
          end else if (refund_req) begin
            // The first refund coin goes out in the very next cycle, so it is
            // issued here and only the remainder is stored.
            state  <= PAYOUT;
            credit <= '0;
            busy   <= 1'b1;
            if (credit >= TWO_W) begin
              money_one <= 1'b1;
              change    <= credit - TWO_W;
            end else begin
              money_half <= 1'b1;
              change     <= credit - ONE_W;
            end
          end
        end
        VEND, PAYOUT: begin
          if (change != '0) begin
            state <= PAYOUT;
            busy  <= 1'b1;
            if (change >= TWO_W) begin
              money_one <= 1'b1;
              change    <= change - TWO_W;
            end else begin
              money_half <= 1'b1;
              change     <= change - ONE_W;
            end
          end else begin
            state <= ACCEPT;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ACCEPT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.po_beverage   = beverage;
  assign bus.po_money_one  = money_one;
  assign bus.po_money_half = money_half;
  assign bus.po_busy       = busy;
  assign bus.po_credit     = credit;

endmodule

// File: doc/vending_machine_param.md
Name: vending_machine_param

Overview:
Parametrised successor to the fixed-price 1.5-unit beverage vending FSM.
- Accumulates half-unit and one-unit coins against a configurable price.
- Vends for one cycle and dispenses change as a sequence of coin pulses.
- Supports a customer cancel that refunds all held credit coin by coin.
- Sits between the coin acceptor front-end and the dispenser/coin-hopper drivers.

Parameters:
PRICE, 3, beverage price in half-units (3 = 1.5 units); legal range 1..(2**CREDIT_W)-2.
CREDIT_W, 4, width of the credit and change counters; must hold PRICE+1.
TIMEOUT_CYC, 1000, idle cycles before auto-refund (used only with VM_TIMEOUT_EN).

Ports:
sys_clk  in  1  single clock, all logic on rising edge.
sys_rst_n  in  1  synchronous active-low reset, sampled on sys_clk rising edge.
pi_money_one  in  1  one-unit coin strobe, 1 cycle per coin.
pi_money_half  in  1  half-unit coin strobe, 1 cycle per coin.
pi_cancel  in  1  cancel strobe; refunds held credit.
po_beverage  out  1  dispense pulse, exactly 1 cycle per sale.
po_money_one  out  1  one-unit change/refund coin pulse.
po_money_half  out  1  half-unit change/refund coin pulse.
po_busy  out  1  high in VEND/PAYOUT; coins and cancel are ignored while high.
po_credit  out  CREDIT_W  current held credit in half-units.

Behaviour:
Reset:
- sys_rst_n low at an edge forces state ACCEPT, credit = 0, change = 0, all outputs 0.
- Reset dominates all other inputs.
- Reset mid-PAYOUT abandons the remaining change. No refund on reset.

Input decode, sampled only in ACCEPT:
- coin value = 2 for pi_money_one alone, 1 for pi_money_half alone.
- Both coin strobes high in the same cycle is invalid: value 0, credit unchanged.

States:
- ACCEPT
  - If a coin is valid and sum = credit + value is at least PRICE: next state VEND, change <= sum - PRICE, credit <= 0.
  - Else if a coin is valid: credit <= sum.
  - Else if pi_cancel = 1 and credit > 0: next state PAYOUT, change <= credit, credit <= 0.
  - A coin wins over pi_cancel in the same cycle; the cancel is dropped.
  - pi_cancel with credit = 0 has no effect.
- VEND
  - Lasts exactly 1 cycle; po_beverage = 1.
  - Next state is PAYOUT if change > 0, else ACCEPT.
- PAYOUT
  - One coin pulse per cycle.
  - If change >= 2: po_money_one = 1, change -= 2. Else: po_money_half = 1, change -= 1.
  - Return to ACCEPT on the cycle after the pulse that brings change to 0.
  - po_money_one and po_money_half are never high together.

Outputs and timing:
- All outputs are registered and updated on the same edge as the state.
- Latency: a completing coin sampled at edge N gives po_beverage high in cycle N..N+1. The first change pulse follows in the next cycle.
- po_busy = 1 exactly when state is VEND or PAYOUT.
- po_credit reflects the credit register.
- Arithmetic is unsigned, CREDIT_W wide. Overflow cannot occur because credit < PRICE before a coin adds at most 2.

Optional Feature:
Macro VM_TIMEOUT_EN.
- Defined:
  - An idle counter, wide enough to count to TIMEOUT_CYC, clears on every valid coin and whenever credit = 0.
  - In ACCEPT with credit > 0, it increments each cycle with no valid coin.
  - On reaching TIMEOUT_CYC, behaves exactly as pi_cancel: enter PAYOUT with change = credit, and the counter clears.
  - Synchronous reset clears the counter.
- Undefined:
  - No counter is built and credit is held indefinitely.
  - TIMEOUT_CYC is unused.

Test Plan:
1. PRICE=3: half, half, half on separate cycles -> po_credit 1, 2, then po_beverage = 1 for 1 cycle after the third coin, no change pulses, po_credit = 0.
2. PRICE=3: one, one -> po_beverage for 1 cycle, then po_money_half for 1 cycle, then ACCEPT with po_busy = 0.
3. PRICE=7: one, half, one (credit 5), then pi_cancel -> po_money_one, po_money_one, po_money_half on 3 consecutive cycles, no po_beverage, credit 0.
4. PRICE=3: both coin strobes together -> credit unchanged. A coin strobe during PAYOUT is ignored (credit stays 0 afterwards). A coin and pi_cancel together with credit 1 -> coin credited, cancel dropped.
5. PRICE=7: credit 5, cancel, sys_rst_n low on the second PAYOUT cycle -> next edge all outputs 0, credit 0, state ACCEPT, no further pulses.
6. VM_TIMEOUT_EN, TIMEOUT_CYC=8, PRICE=7:
   - Insert one coin, then idle -> po_money_one after 8 idle cycles plus 1, credit 0.
   - A coin at idle cycle 7 restarts the count.
